// File: rtl/l1_d_controller_nway.sv
// Set-associative write-back / write-allocate L1 data-cache controller with true LRU
// replacement and a dirty-line flush. Drives way selection for the external data array.

module l1_d_way_match #(
    parameter int TAG_W = 20
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] stored,
    input  logic [TAG_W-1:0] tag,
    output logic             hit
);
    assign hit = valid && (stored == tag);
endmodule

module l1_d_controller_nway #(
    parameter  int TAG_W = 20,
    parameter  int IDX_W = 6,
    parameter  int WAYS  = 2,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [TAG_W-1:0] tag,
    input  logic [IDX_W-1:0] index,
    input  logic             read_C_L1,
    input  logic             write_C_L1,
    input  logic             flush,
    input  logic             ready_L2_L1,
    output logic             stall,
    output logic             refill,
    output logic             update,
    output logic             read_L1_L2,
    output logic             write_L1_L2,
    output logic [WAY_W-1:0] way_sel,
    output logic [TAG_W-1:0] wb_tag,
    output logic [IDX_W-1:0] wb_index,
    output logic             flush_done
);
    localparam int SETS  = 1 << IDX_W;
    localparam int CNT_W = IDX_W + WAY_W;
    localparam int LINES = SETS * WAYS;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB} state_t;
    state_t state, state_nx;

    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_mem;
    logic [SETS-1:0][WAYS-1:0]            valid_mem;
    logic [SETS-1:0][WAYS-1:0]            dirty_mem;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_mem;

    logic [WAY_W-1:0] way_q;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] f_set;
    logic [WAY_W-1:0] f_way;
    logic             line_dirty, last_line;

    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way, victim, acc_way;
    logic             victim_dirty, acc_en, ready;

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_match
            l1_d_way_match #(.TAG_W(TAG_W)) u_match (
                .valid (valid_mem[index][g]),
                .stored(tag_mem[index][g]),
                .tag   (tag),
                .hit   (hit_vec[g])
            );
        end
    endgenerate

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (hit_vec[w]) hit_way = WAY_W'(w);
    end

    // Prefer the lowest invalid way; otherwise the oldest way of the set.
    always_comb begin
        logic found;
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (!valid_mem[index][w] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        if (!found)
            for (int w = 0; w < WAYS; w++)
                if (age_mem[index][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end

    assign victim_dirty = valid_mem[index][victim] && dirty_mem[index][victim];

    // Flush counter walks lines set-major, way-minor.
    assign f_set      = IDX_W'(cnt / CNT_W'(WAYS));
    assign f_way      = WAY_W'(cnt % CNT_W'(WAYS));
    assign line_dirty = valid_mem[f_set][f_way] && dirty_mem[f_set][f_way];
    assign last_line  = (cnt == CNT_W'(LINES - 1));

    assign ready   = ready_L2_L1;
    assign acc_en  = (state == COMPARE && hit) || (state == ALLOCATE && ready);
    assign acc_way = (state == COMPARE) ? hit_way : way_q;

    assign stall       = (state != IDLE);
    assign read_L1_L2  = (state == ALLOCATE);
    assign write_L1_L2 = (state == WRITE_BACK) || (state == FLUSH_WB);
    assign way_sel     = (state == COMPARE && hit) ? hit_way : way_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (flush) state_nx = FLUSH_SCAN;
                        else if (read_C_L1 || write_C_L1) state_nx = COMPARE;
            COMPARE:    if (hit) state_nx = IDLE;
                        else if (victim_dirty) state_nx = WRITE_BACK;
                        else state_nx = ALLOCATE;
            WRITE_BACK: if (ready) state_nx = ALLOCATE;
            ALLOCATE:   if (ready) state_nx = IDLE;
            FLUSH_SCAN: if (line_dirty) state_nx = FLUSH_WB;
                        else if (last_line) state_nx = IDLE;
            FLUSH_WB:   if (ready) state_nx = last_line ? IDLE : FLUSH_SCAN;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            tag_mem    <= '0;
            valid_mem  <= '0;
            dirty_mem  <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_mem[s][w] <= WAY_W'(w);
            way_q      <= '0;
            wb_tag     <= '0;
            wb_index   <= '0;
            cnt        <= '0;
            refill     <= 1'b0;
            update     <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nx;
            refill     <= 1'b0;
            update     <= 1'b0;
            flush_done <= 1'b0;

            if (acc_en) begin
                for (int w = 0; w < WAYS; w++)
                    if (age_mem[index][w] < age_mem[index][acc_way])
                        age_mem[index][w] <= age_mem[index][w] + 1'b1;
                age_mem[index][acc_way] <= '0;
            end

            case (state)
                COMPARE: begin
                    if (hit) begin
                        way_q <= hit_way;
                        if (write_C_L1) begin
                            dirty_mem[index][hit_way] <= 1'b1;
                            update                    <= 1'b1;
                        end
                    end else begin
                        way_q    <= victim;
                        wb_tag   <= tag_mem[index][victim];
                        wb_index <= index;
                    end
                end
                WRITE_BACK: if (ready) dirty_mem[index][way_q] <= 1'b0;
                ALLOCATE: if (ready) begin
                    tag_mem[index][way_q]   <= tag;
                    valid_mem[index][way_q] <= 1'b1;
                    dirty_mem[index][way_q] <= write_C_L1;
                    refill                  <= !write_C_L1;
                    update                  <= write_C_L1;
                end
                FLUSH_SCAN: begin
                    if (line_dirty) begin
                        way_q    <= f_way;
                        wb_tag   <= tag_mem[f_set][f_way];
                        wb_index <= f_set;
                    end else if (last_line) begin
                        valid_mem  <= '0;
                        cnt        <= '0;
                        flush_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FLUSH_WB: if (ready) begin
                    dirty_mem[f_set][f_way] <= 1'b0;
                    if (last_line) begin
                        valid_mem  <= '0;
                        cnt        <= '0;
                        flush_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_d_controller_nway.sv
// Directed bench for l1_d_controller_nway (WAYS=2): vector table for the first miss/hit,
// then hand-written sequences for LRU, write-back, write-allocate, flush and mid-op reset.

module tb_l1_d_controller_nway;
    logic        clk = 1'b0;
    logic        nrst;
    logic [19:0] tag;
    logic [5:0]  index;
    logic        read_C_L1, write_C_L1, flush, ready_L2_L1;
    logic        stall, refill, update, read_L1_L2, write_L1_L2, flush_done;
    logic [0:0]  way_sel;
    logic [19:0] wb_tag;
    logic [5:0]  wb_index;

    int total = 0;
    int passed = 0;

    l1_d_controller_nway #(.TAG_W(20), .IDX_W(6), .WAYS(2)) dut (
        .clk(clk), .nrst(nrst), .tag(tag), .index(index),
        .read_C_L1(read_C_L1), .write_C_L1(write_C_L1), .flush(flush),
        .ready_L2_L1(ready_L2_L1), .stall(stall), .refill(refill), .update(update),
        .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .way_sel(way_sel),
        .wb_tag(wb_tag), .wb_index(wb_index), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, rdy;
        logic        stall, rl2, refill, update, way;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; read_C_L1 = 0; write_C_L1 = 0; flush = 0; ready_L2_L1 = 0;
        tag = '0; index = '0;
        step();
        step();
        nrst = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " stall"}, 32'(stall), 0);
        chk({nm, " refill"}, 32'(refill), 0);
        chk({nm, " update"}, 32'(update), 0);
        chk({nm, " read_L1_L2"}, 32'(read_L1_L2), 0);
        chk({nm, " write_L1_L2"}, 32'(write_L1_L2), 0);
        chk({nm, " way_sel"}, 32'(way_sel), 0);
        chk({nm, " wb_tag"}, 32'(wb_tag), 0);
        chk({nm, " wb_index"}, 32'(wb_index), 0);
        chk({nm, " flush_done"}, 32'(flush_done), 0);
    endtask

    // Full core transaction starting and ending at a negedge in IDLE.
    task automatic access(input string nm, input logic [19:0] t, input logic [5:0] ix,
                          input bit wr, input bit exp_hit, input bit exp_wb,
                          input logic [19:0] exp_wbt, input logic exp_way);
        tag = t; index = ix; read_C_L1 = !wr; write_C_L1 = wr; ready_L2_L1 = 0;
        step();
        chk({nm, " compare stall"}, 32'(stall), 1);
        if (exp_hit) begin
            chk({nm, " hit way"}, 32'(way_sel), 32'(exp_way));
            step();
            read_C_L1 = 0; write_C_L1 = 0;
            chk({nm, " hit stall"}, 32'(stall), 0);
            chk({nm, " hit update"}, 32'(update), 32'(wr));
            chk({nm, " hit refill"}, 32'(refill), 0);
        end else begin
            step();
            if (exp_wb) begin
                chk({nm, " wb write_L1_L2"}, 32'(write_L1_L2), 1);
                chk({nm, " wb read_L1_L2"}, 32'(read_L1_L2), 0);
                chk({nm, " wb_tag"}, 32'(wb_tag), 32'(exp_wbt));
                chk({nm, " wb_index"}, 32'(wb_index), 32'(ix));
                ready_L2_L1 = 1;
                step();
                ready_L2_L1 = 0;
            end
            chk({nm, " alloc read_L1_L2"}, 32'(read_L1_L2), 1);
            chk({nm, " alloc write_L1_L2"}, 32'(write_L1_L2), 0);
            chk({nm, " victim way"}, 32'(way_sel), 32'(exp_way));
            ready_L2_L1 = 1;
            step();
            ready_L2_L1 = 0; read_C_L1 = 0; write_C_L1 = 0;
            chk({nm, " done stall"}, 32'(stall), 0);
            chk({nm, " refill"}, 32'(refill), 32'(!wr));
            chk({nm, " update"}, 32'(update), 32'(wr));
            step();
            chk({nm, " pulse end"}, 32'(refill | update), 0);
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   nwb;
        bit   done;
        logic [19:0] wbt[2];
        logic [5:0]  wbi[2];
        logic        wbw[2];

        // {rd, rdy, stall, read_L1_L2, refill, update, way_sel}
        vecs[0] = '{1, 0, 1, 0, 0, 0, 0};  // IDLE -> COMPARE (miss)
        vecs[1] = '{1, 0, 1, 1, 0, 0, 0};  // -> ALLOCATE
        vecs[2] = '{1, 0, 1, 1, 0, 0, 0};  // waiting for L2
        vecs[3] = '{1, 1, 0, 0, 1, 0, 0};  // ready -> IDLE, refill pulse
        vecs[4] = '{0, 1, 0, 0, 0, 0, 0};  // stray ready in IDLE is ignored
        vecs[5] = '{1, 0, 1, 0, 0, 0, 0};  // repeat read -> COMPARE hit way0
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0};  // back to IDLE after one stall cycle

        do_reset();
        chk_all_zero("reset");

        tag = 20'h00001; index = 6'd5; write_C_L1 = 0;
        for (int i = 0; i < 7; i++) begin
            read_C_L1 = vecs[i].rd; ready_L2_L1 = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].stall));
            chk($sformatf("vec%0d read_L1_L2", i), 32'(read_L1_L2), 32'(vecs[i].rl2));
            chk($sformatf("vec%0d refill", i), 32'(refill), 32'(vecs[i].refill));
            chk($sformatf("vec%0d update", i), 32'(update), 32'(vecs[i].update));
            chk($sformatf("vec%0d way_sel", i), 32'(way_sel), 32'(vecs[i].way));
        end
        read_C_L1 = 0; ready_L2_L1 = 0;

        // LRU: A touched after B, so C evicts B (way1)
        access("lruA fillA", 20'hA, 6'd3, 0, 0, 0, 0, 0);
        access("lruA fillB", 20'hB, 6'd3, 0, 0, 0, 0, 1);
        access("lruA hitA",  20'hA, 6'd3, 0, 1, 0, 0, 0);
        access("lruA missC", 20'hC, 6'd3, 0, 0, 0, 0, 1);
        // LRU: B touched last, so C evicts A (way0)
        access("lruB fillA", 20'hA, 6'd4, 0, 0, 0, 0, 0);
        access("lruB fillB", 20'hB, 6'd4, 0, 0, 0, 0, 1);
        access("lruB hitB",  20'hB, 6'd4, 0, 1, 0, 0, 1);
        access("lruB missC", 20'hC, 6'd4, 0, 0, 0, 0, 0);

        // Write hit makes A dirty; evicting it writes back tag A, set 3
        access("whit A",  20'hA, 6'd3, 1, 1, 0, 0, 0);
        access("hit C",   20'hC, 6'd3, 0, 1, 0, 0, 1);
        access("evict A", 20'hD, 6'd3, 0, 0, 1, 20'hA, 0);

        // Write miss allocates a dirty line (update, no refill)
        access("wmiss E", 20'hE, 6'd10, 1, 0, 0, 0, 0);
        access("fill F",  20'hF, 6'd10, 0, 0, 0, 0, 1);
        access("evict E", 20'h12, 6'd10, 0, 0, 1, 20'hE, 0);

        // Flush: dirty lines at (0, way1) and (63, way0)
        do_reset();
        access("fl H", 20'h100, 6'd0, 0, 0, 0, 0, 0);
        access("fl J", 20'h200, 6'd0, 1, 0, 0, 0, 1);
        access("fl K", 20'h300, 6'd63, 1, 0, 0, 0, 0);
        flush = 1;
        step();
        flush = 0;
        nwb = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (flush_done) done = 1;
            else if (write_L1_L2) begin
                if (nwb < 2) begin
                    wbt[nwb] = wb_tag; wbi[nwb] = wb_index; wbw[nwb] = way_sel;
                end
                nwb++;
                ready_L2_L1 = 1;
                step();
                ready_L2_L1 = 0;
            end else step();
        end
        chk("flush done seen", 32'(done), 1);
        chk("flush wb count", 32'(nwb), 2);
        chk("flush stall at done", 32'(stall), 0);
        chk("flush wb0 tag", 32'(wbt[0]), 32'h200);
        chk("flush wb0 index", 32'(wbi[0]), 0);
        chk("flush wb0 way", 32'(wbw[0]), 1);
        chk("flush wb1 tag", 32'(wbt[1]), 32'h300);
        chk("flush wb1 index", 32'(wbi[1]), 63);
        chk("flush wb1 way", 32'(wbw[1]), 0);
        step();
        chk("flush_done one cycle", 32'(flush_done), 0);
        access("post flush H", 20'h100, 6'd0, 0, 0, 0, 0, 0);
        access("post flush K", 20'h300, 6'd63, 0, 0, 0, 0, 0);

        // Reset during WRITE_BACK with ready low
        access("rst whit K", 20'h300, 6'd63, 1, 1, 0, 0, 0);
        access("rst fill L", 20'h400, 6'd63, 0, 0, 0, 0, 1);
        tag = 20'h500; index = 6'd63; read_C_L1 = 1;
        step();
        step();
        chk("rst in wb", 32'(write_L1_L2), 1);
        chk("rst wb_tag", 32'(wb_tag), 32'h300);
        nrst = 1'b0;
        #1;
        chk_all_zero("midop reset");
        read_C_L1 = 0;
        @(negedge clk);
        nrst = 1'b1;
        access("rst K misses", 20'h300, 6'd63, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
